// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, reset, start/op/rs1_val/rs2_val/rd_in in; busy/done/result/rd_out out.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs1_val,
  input  logic [WIDTH-1:0]   rs2_val,
  input  logic [RD_BITS-1:0] rd_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [RD_BITS-1:0] rd_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]         op_q;
  logic [RD_BITS-1:0] rd_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fin_q;
  logic               spec_q;
  logic               neg_q;
  logic               neg_r_q;

  logic               sa;
  logic               sb;
  logic               a_msb;
  logic               b_msb;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               div0;
  logic               ovf;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   q_f;
  logic [WIDTH-1:0]   r_f;
  logic [WIDTH-1:0]   fin_res;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = op[2] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        if (fin_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand signedness: A signed except MULHU/DIVU/REMU,
  // B signed only for MUL/MULH/DIV/REM.
  always_comb begin
    sa    = op[2] ? ~op[0] : (op != 3'd3);
    sb    = op[2] ? ~op[0] : ~op[1];
    a_msb = rs1_val[WIDTH-1];
    b_msb = rs2_val[WIDTH-1];
    a_abs = (sa && a_msb) ? -rs1_val : rs1_val;
    b_abs = (sb && b_msb) ? -rs2_val : rs2_val;
    div0  = op[2] && (rs2_val == '0);
    ovf   = op[2] && !op[0]
            && (rs1_val == {1'b1, {(WIDTH-1){1'b0}}})
            && (rs2_val == '1);
  end

  // One iteration of each algorithm plus final sign fix-up.
  always_comb begin
    mul_sum = {1'b0, acc_hi}
            + {1'b0, (acc_lo[0] ? opnd_q : {WIDTH{1'b0}})};
    r_sh    = {acc_hi, acc_lo[WIDTH-1]};
    diff    = r_sh - {1'b0, opnd_q};
    prod    = {acc_hi, acc_lo};
    prod_f  = neg_q ? -prod : prod;
    q_f     = neg_q ? -acc_lo : acc_lo;
    r_f     = neg_r_q ? -acc_hi : acc_hi;
    fin_res = '0;
    unique case (1'b1)
      (state_q == MUL):
        fin_res = (op_q == 3'd0) ? prod_f[WIDTH-1:0]
                                 : prod_f[2*WIDTH-1:WIDTH];
      (state_q == DIV):
        fin_res = spec_q ? acc_lo : (op_q[1] ? r_f : q_f);
      default: fin_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      rd_q    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      spec_q  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            rd_q    <= rd_in;
            acc_hi  <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            fin_q   <= 1'b0;
            spec_q  <= 1'b0;
            neg_r_q <= 1'b0;
            if (!op[2]) begin
              acc_lo <= b_abs;
              opnd_q <= a_abs;
              neg_q  <= (sa & a_msb) ^ (sb & b_msb);
            end else begin
              acc_lo  <= a_abs;
              opnd_q  <= b_abs;
              neg_q   <= sa & (a_msb ^ b_msb);
              neg_r_q <= sa & a_msb;
              // Special cases preload the final value and
              // leave after a single cycle in DIV.
              if (div0 || ovf) begin
                spec_q <= 1'b1;
                fin_q  <= 1'b1;
                if (div0) begin
                  acc_lo <= op[1] ? rs1_val : '1;
                end else begin
                  acc_lo <= op[1] ? '0 : rs1_val;
                end
              end
            end
          end
        end
        MUL, DIV: begin
          if (fin_q) begin
            result <= fin_res;
            rd_out <= rd_q;
          end else begin
            if (state_q == MUL) begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
              acc_hi <= diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= r_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
              fin_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
